// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file with two write ports,
// optional same-cycle write-to-read bypass, optional hardwired-zero register 0
// and a sequenced bulk-clear engine.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   ra       NUM_RD packed read addresses, port k = ra[k*AW +: AW]
//   rd       NUM_RD packed read data,      port k = rd[k*N  +: N]
//   we3/wa3/wd3  write port A (wins address collisions)
//   we4/wa4/wd4  write port B
//   clr      start bulk clear (sampled only while idle)
//   busy     clear engine active
//   wr_drop  registered pulse: an asserted write was discarded last cycle
module regfile_mp #(
  parameter int N       = 8,
  parameter int DEPTH   = 8,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD*N-1:0]  rd,
  input  logic                 we3,
  input  logic [AW-1:0]        wa3,
  input  logic [N-1:0]         wd3,
  input  logic                 we4,
  input  logic [AW-1:0]        wa4,
  input  logic [N-1:0]         wd4,
  input  logic                 clr,
  output logic                 busy,
  output logic                 wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            wr_drop_reg;
  logic [N-1:0]    mem_reg [DEPTH];

  logic            busy_now;
  logic            r0_a, r0_b;
  logic            acc_a, acc_b;
  logic            drop_now;

  assign busy_now = (state_reg == CLEAR);

  // Writes aimed at a hardwired-zero register 0 are treated as discarded.
  assign r0_a = (R0_ZERO != 0) && (wa3 == '0);
  assign r0_b = (R0_ZERO != 0) && (wa4 == '0);

  // Accepted writes: only these commit and only these may be forwarded.
  // Port B loses any address collision with an asserted port A.
  assign acc_a = we3 && !busy_now && !r0_a;
  assign acc_b = we4 && !busy_now && !r0_b && !(we3 && (wa3 == wa4));

  assign drop_now = (we3 && !acc_a) || (we4 && !acc_b);

  // Clear-engine FSM, next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + AW'(1);
        // Leave on the edge that clears the last register, so busy spans
        // exactly DEPTH cycles.
        if (cnt_reg == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_drop_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_drop_reg <= drop_now;
    end
  end

  // Storage. During CLEAR only the engine writes; both user ports are gated
  // off through acc_a/acc_b.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (busy_now) begin
      mem_reg[cnt_reg] <= '0;
    end else begin
      if (acc_a) begin
        mem_reg[wa3] <= wd3;
      end
      if (acc_b) begin
        mem_reg[wa4] <= wd4;
      end
    end
  end

  // Combinational read ports.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic [N-1:0]  rd_val;

      assign addr = ra[gi*AW +: AW];

      always_comb begin
        rd_val = mem_reg[addr];
        if (BYPASS != 0) begin
          if (acc_a && (addr == wa3)) begin
            rd_val = wd3;
          end else if (acc_b && (addr == wa4)) begin
            rd_val = wd4;
          end
        end
        if ((R0_ZERO != 0) && (addr == '0)) begin
          rd_val = '0;
        end
      end

      assign rd[gi*N +: N] = rd_val;
    end
  endgenerate

  assign busy    = busy_now;
  assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp.
// Three instances share one stimulus: nb (BYPASS=0), bp (BYPASS=1) and
// z (BYPASS=1, R0_ZERO=1).
`timescale 1ns/1ps
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [5:0]  ra;
  logic        we3, we4, clr;
  logic [2:0]  wa3, wa4;
  logic [7:0]  wd3, wd4;
  logic [15:0] rd_nb, rd_bp, rd_z;
  logic        busy_nb, busy_bp, busy_z;
  logic        wr_drop_nb, wr_drop_bp, wr_drop_z;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  logic [2:0] addr_v;

  regfile_mp #(.N(8), .DEPTH(8), .NUM_RD(2), .BYPASS(0), .R0_ZERO(0)) dut_nb (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_nb),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .clr(clr), .busy(busy_nb), .wr_drop(wr_drop_nb));

  regfile_mp #(.N(8), .DEPTH(8), .NUM_RD(2), .BYPASS(1), .R0_ZERO(0)) dut_bp (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_bp),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .clr(clr), .busy(busy_bp), .wr_drop(wr_drop_bp));

  regfile_mp #(.N(8), .DEPTH(8), .NUM_RD(2), .BYPASS(1), .R0_ZERO(1)) dut_z (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_z),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .clr(clr), .busy(busy_z), .wr_drop(wr_drop_z));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ra = '0; we3 = 0; we4 = 0; clr = 0;
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (busy_nb !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_nb); end
    checks++; if (wr_drop_nb !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop_nb); end
    for (int i = 0; i < 8; i++) begin
      addr_v = 3'(i);
      ra = {addr_v, addr_v};
      #1;
      checks++; if (rd_nb !== 16'h0000) begin errors++; $display("FAIL reset_read addr %0d: got %h expected 0000", i, rd_nb); end
    end
    $display("reset: %0d checks so far", checks);
  endtask

  task automatic test_basic();
    we3 = 1; wa3 = 3'd1; wd3 = 8'hAB; ra = {3'd0, 3'd1};
    #1;
    checks++; if (rd_nb[7:0] !== 8'h00) begin errors++; $display("FAIL basic_same_cycle_old: got %h expected 00", rd_nb[7:0]); end
    checks++; if (rd_bp[7:0] !== 8'hAB) begin errors++; $display("FAIL basic_bypass_a: got %h expected ab", rd_bp[7:0]); end
    tick();
    we3 = 0; we4 = 1; wa4 = 3'd4; wd4 = 8'h5C;
    #1;
    tick();
    we4 = 0; ra = {3'd4, 3'd1};
    #1;
    checks++; if (rd_nb[7:0] !== 8'hAB) begin errors++; $display("FAIL basic_rd0: got %h expected ab", rd_nb[7:0]); end
    checks++; if (rd_nb[15:8] !== 8'h5C) begin errors++; $display("FAIL basic_rd1: got %h expected 5c", rd_nb[15:8]); end
    checks++; if (wr_drop_nb !== 1'b0) begin errors++; $display("FAIL basic_no_drop: got %b expected 0", wr_drop_nb); end
    $display("basic write/read: rd0=%h rd1=%h", rd_nb[7:0], rd_nb[15:8]);
  endtask

  task automatic test_collision();
    we3 = 1; we4 = 1; wa3 = 3'd3; wa4 = 3'd3; wd3 = 8'h11; wd4 = 8'h22; ra = {3'd3, 3'd3};
    #1;
    checks++; if (rd_bp[7:0] !== 8'h11) begin errors++; $display("FAIL coll_bypass_rd0: got %h expected 11", rd_bp[7:0]); end
    checks++; if (rd_bp[15:8] !== 8'h11) begin errors++; $display("FAIL coll_bypass_rd1: got %h expected 11", rd_bp[15:8]); end
    checks++; if (rd_nb[7:0] !== 8'h00) begin errors++; $display("FAIL coll_nobypass: got %h expected 00", rd_nb[7:0]); end
    tick();
    we3 = 0; we4 = 0;
    #1;
    checks++; if (wr_drop_bp !== 1'b1) begin errors++; $display("FAIL coll_drop: got %b expected 1", wr_drop_bp); end
    checks++; if (rd_bp[7:0] !== 8'h11) begin errors++; $display("FAIL coll_stored_bp: got %h expected 11", rd_bp[7:0]); end
    checks++; if (rd_nb[7:0] !== 8'h11) begin errors++; $display("FAIL coll_stored_nb: got %h expected 11", rd_nb[7:0]); end
    tick();
    checks++; if (wr_drop_bp !== 1'b0) begin errors++; $display("FAIL coll_drop_clears: got %b expected 0", wr_drop_bp); end
    $display("collision: reg3=%h", rd_bp[7:0]);
  endtask

  task automatic test_r0();
    we3 = 1; wa3 = 3'd0; wd3 = 8'hFF; ra = {3'd0, 3'd0};
    #1;
    checks++; if (rd_z[7:0] !== 8'h00) begin errors++; $display("FAIL r0_same_cycle: got %h expected 00", rd_z[7:0]); end
    checks++; if (rd_bp[7:0] !== 8'hFF) begin errors++; $display("FAIL r0_plain_bypass: got %h expected ff", rd_bp[7:0]); end
    tick();
    we3 = 0;
    #1;
    checks++; if (rd_z[7:0] !== 8'h00) begin errors++; $display("FAIL r0_next_cycle: got %h expected 00", rd_z[7:0]); end
    checks++; if (wr_drop_z !== 1'b1) begin errors++; $display("FAIL r0_drop: got %b expected 1", wr_drop_z); end
    checks++; if (wr_drop_bp !== 1'b0) begin errors++; $display("FAIL r0_plain_no_drop: got %b expected 0", wr_drop_bp); end
    tick();
    checks++; if (wr_drop_z !== 1'b0) begin errors++; $display("FAIL r0_drop_clears: got %b expected 0", wr_drop_z); end
    $display("r0 zero: rd0=%h", rd_z[7:0]);
  endtask

  task automatic test_back_to_back();
    we3 = 1; wa3 = 3'd5; wd3 = 8'hA5; we4 = 1; wa4 = 3'd6; wd4 = 8'hB6; ra = {3'd6, 3'd5};
    #1;
    checks++; if (rd_bp !== 16'hB6A5) begin errors++; $display("FAIL b2b_bypass_both: got %h expected b6a5", rd_bp); end
    tick();
    we3 = 0; we4 = 0;
    #1;
    checks++; if (rd_nb !== 16'hB6A5) begin errors++; $display("FAIL b2b_stored: got %h expected b6a5", rd_nb); end
    checks++; if (wr_drop_nb !== 1'b0) begin errors++; $display("FAIL b2b_no_drop: got %b expected 0", wr_drop_nb); end
    $display("back-to-back dual write: rd=%h", rd_nb);
  endtask

  task automatic test_bulk_clear();
    for (int i = 0; i < 8; i++) begin
      we3 = 1; wa3 = 3'(i); wd3 = 8'h10 + 8'(i);
      tick();
    end
    we3 = 0; ra = {3'd7, 3'd0};
    #1;
    checks++; if (rd_nb !== 16'h1710) begin errors++; $display("FAIL clr_fill: got %h expected 1710", rd_nb); end
    clr = 1;
    tick();
    clr = 0;
    #1;
    busy_cnt = 0;
    if (busy_nb === 1'b1) busy_cnt++;
    checks++; if (rd_nb[7:0] !== 8'h10) begin errors++; $display("FAIL clr_before_first: got %h expected 10", rd_nb[7:0]); end
    tick();
    if (busy_nb === 1'b1) busy_cnt++;
    checks++; if (rd_nb !== 16'h1700) begin errors++; $display("FAIL clr_partial: got %h expected 1700", rd_nb); end
    // write and restart attempt while busy: both must be ignored
    we3 = 1; wa3 = 3'd0; wd3 = 8'hAA; clr = 1;
    #1;
    checks++; if (rd_bp[7:0] !== 8'h00) begin errors++; $display("FAIL clr_no_bypass: got %h expected 00", rd_bp[7:0]); end
    tick();
    we3 = 0; clr = 0;
    if (busy_nb === 1'b1) busy_cnt++;
    checks++; if (wr_drop_nb !== 1'b1) begin errors++; $display("FAIL clr_busy_drop: got %b expected 1", wr_drop_nb); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy_nb === 1'b1) busy_cnt++;
      else break;
    end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL clr_busy_len: got %0d expected 8", busy_cnt); end
    for (int i = 0; i < 8; i++) begin
      addr_v = 3'(i);
      ra = {addr_v, addr_v};
      #1;
      checks++; if (rd_nb !== 16'h0000) begin errors++; $display("FAIL clr_done addr %0d: got %h expected 0000", i, rd_nb); end
    end
    $display("bulk clear: busy cycles=%0d", busy_cnt);
  endtask

  task automatic test_reset_mid_clear();
    we3 = 1; wa3 = 3'd7; wd3 = 8'h77;
    tick();
    we3 = 0; clr = 1;
    tick();
    clr = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (busy_nb !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_nb); end
    for (int i = 0; i < 8; i++) begin
      addr_v = 3'(i);
      ra = {addr_v, addr_v};
      #1;
      checks++; if (rd_nb !== 16'h0000) begin errors++; $display("FAIL midrst_read addr %0d: got %h expected 0000", i, rd_nb); end
    end
    we3 = 1; wa3 = 3'd2; wd3 = 8'h5A; ra = {3'd2, 3'd2};
    tick();
    we3 = 0;
    #1;
    checks++; if (rd_nb !== 16'h5A5A) begin errors++; $display("FAIL midrst_write: got %h expected 5a5a", rd_nb); end
    checks++; if (wr_drop_nb !== 1'b0) begin errors++; $display("FAIL midrst_no_drop: got %b expected 0", wr_drop_nb); end
    $display("reset mid-clear: reg2=%h", rd_nb[7:0]);
  endtask

  task automatic test_clr_with_write();
    we3 = 1; wa3 = 3'd4; wd3 = 8'h44; clr = 1; ra = {3'd4, 3'd4};
    tick();
    we3 = 0; clr = 0;
    #1;
    checks++; if (busy_nb !== 1'b1) begin errors++; $display("FAIL clrw_busy: got %b expected 1", busy_nb); end
    checks++; if (rd_nb[7:0] !== 8'h44) begin errors++; $display("FAIL clrw_committed: got %h expected 44", rd_nb[7:0]); end
    checks++; if (wr_drop_nb !== 1'b0) begin errors++; $display("FAIL clrw_no_drop: got %b expected 0", wr_drop_nb); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy_nb !== 1'b1) break;
    end
    checks++; if (busy_nb !== 1'b0) begin errors++; $display("FAIL clrw_timeout: got %b expected 0", busy_nb); end
    checks++; if (rd_nb[7:0] !== 8'h00) begin errors++; $display("FAIL clrw_cleared: got %h expected 00", rd_nb[7:0]); end
    $display("clear with write: reg4=%h", rd_nb[7:0]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_r0();
    test_back_to_back();
    test_bulk_clear();
    test_reset_mid_clear();
    test_clr_with_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
